// File: rtl/field_layer_classifier_pkg.sv
// Shared types and constants for the field layer classifier.
package field_layer_classifier_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StThresh = 2'd1,
    StSample = 2'd2,
    StDrain  = 2'd3
  } state_e;

  localparam int unsigned LABEL_NONE = 1;
  localparam int unsigned CLS_LAT    = 2;

endpackage

// File: rtl/field_layer_classifier_if.sv
// AXI-Stream style channel used for both the field input and the label output.
interface field_layer_classifier_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/field_layer_classifier_layer_compare.sv
// Combinational priority compare of one field against the threshold set.
module field_layer_classifier_layer_compare
  import field_layer_classifier_pkg::*;
#(
  parameter int unsigned FIELD_WIDTH = 32,
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned LAY_NUM     = 2
) (
  input  logic [FIELD_WIDTH-1:0]              field,
  input  logic [LAY_NUM-1:0][FIELD_WIDTH-1:0] thr,
  output logic [OUT_WIDTH-1:0]                label
);

  // Walk from the highest index down so the lowest matching threshold wins.
  always_comb begin
    label = OUT_WIDTH'(LABEL_NONE);
    for (int j = int'(LAY_NUM) - 1; j >= 0; j--) begin
      if ($signed(field) <= $signed(thr[j])) begin
        label = OUT_WIDTH'(int'(LAY_NUM) + 1 - j);
      end
    end
  end

endmodule

// File: rtl/field_layer_classifier.sv
// Framed field stream to layer label stream: header, thresholds, then samples,
// with a two-stage compare/output pipeline under full output backpressure.
module field_layer_classifier
  import field_layer_classifier_pkg::*;
#(
  parameter int unsigned FIELD_WIDTH = 32,
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned LAY_NUM     = 2,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  field_layer_classifier_if.slave  s,
  field_layer_classifier_if.master m,
  output logic                     busy,
  output logic                     err_order,
  output logic                     err_trunc
);

  localparam int unsigned KW = 4;

  state_e                              state_q;
  logic                                run_q;
  logic [COUNT_WIDTH-1:0]              count_q;
  logic [COUNT_WIDTH-1:0]              n_q;
  logic [KW-1:0]                       k_q;
  logic [LAY_NUM-1:0][FIELD_WIDTH-1:0] thr_q;
  logic                                err_order_q;
  logic                                err_trunc_q;

  logic                   s1_valid_q;
  logic [FIELD_WIDTH-1:0] s1_field_q;
  logic                   s1_last_q;
  logic                   out_valid_q;
  logic [OUT_WIDTH-1:0]   out_label_q;
  logic                   out_last_q;

  logic                   s_ready;
  logic                   s_hs;
  logic                   out_adv;
  logic                   s1_load;
  logic [COUNT_WIDTH-1:0] n_next;
  logic                   at_count;
  logic                   trunc;
  logic                   tag_last;
  logic [FIELD_WIDTH-1:0] prev_thr;
  logic                   has_prev;
  logic [OUT_WIDTH-1:0]   label;

  assign out_adv  = !out_valid_q || m.tready;
  assign n_next   = n_q + COUNT_WIDTH'(1);
  assign at_count = (n_next == count_q);
  assign trunc    = s.tlast && !at_count;
  assign tag_last = at_count || s.tlast;

  // run_q keeps s_tready low while reset is asserted and for one cycle after.
  always_comb begin
    s_ready = 1'b0;
    unique case (state_q)
      StIdle:   s_ready = run_q;
      StThresh: s_ready = 1'b1;
      StSample: s_ready = !s1_valid_q || out_adv;
      StDrain:  s_ready = 1'b0;
      default:  s_ready = 1'b0;
    endcase
  end

  assign s_hs    = s.tvalid && s_ready;
  assign s1_load = s_hs && (state_q == StSample);

  always_comb begin
    prev_thr = '0;
    has_prev = 1'b0;
    for (int j = 1; j < int'(LAY_NUM); j++) begin
      if (k_q == KW'(j)) begin
        prev_thr = thr_q[j-1];
        has_prev = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      run_q       <= 1'b0;
      count_q     <= '0;
      n_q         <= '0;
      k_q         <= '0;
      thr_q       <= '0;
      err_order_q <= 1'b0;
      err_trunc_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (s_hs) begin
            count_q     <= s.tdata[COUNT_WIDTH-1:0];
            n_q         <= '0;
            k_q         <= '0;
            err_order_q <= 1'b0;
            err_trunc_q <= 1'b0;
            state_q     <= StThresh;
          end
        end
        StThresh: begin
          if (s_hs) begin
            for (int j = 0; j < int'(LAY_NUM); j++) begin
              if (k_q == KW'(j)) thr_q[j] <= s.tdata;
            end
            if (has_prev && ($signed(s.tdata) <= $signed(prev_thr))) err_order_q <= 1'b1;
            if (k_q == KW'(LAY_NUM - 1)) begin
              k_q     <= '0;
              state_q <= (count_q != '0) ? StSample : StIdle;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        StSample: begin
          if (s_hs) begin
            n_q <= n_next;
            if (trunc) err_trunc_q <= 1'b1;
            if (tag_last) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (out_valid_q && m.tready && out_last_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  field_layer_classifier_layer_compare #(
    .FIELD_WIDTH(FIELD_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .LAY_NUM    (LAY_NUM)
  ) u_compare (
    .field(s1_field_q),
    .thr  (thr_q),
    .label(label)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid_q  <= 1'b0;
      s1_field_q  <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_label_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (out_adv) begin
        out_valid_q <= s1_valid_q;
        out_last_q  <= s1_valid_q && s1_last_q;
        if (s1_valid_q) out_label_q <= label;
      end
      if (s1_load) begin
        s1_valid_q <= 1'b1;
        s1_field_q <= s.tdata;
        s1_last_q  <= tag_last;
      end else if (out_adv) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  assign s.tready  = s_ready;
  assign m.tdata   = out_label_q;
  assign m.tvalid  = out_valid_q;
  assign m.tlast   = out_last_q;
  assign busy      = (state_q != StIdle);
  assign err_order = err_order_q;
  assign err_trunc = err_trunc_q;

endmodule

// File: tb/tb_field_layer_classifier.sv
// Directed bench for field_layer_classifier: LAY_NUM=2 and LAY_NUM=4 builds
// checked against a label scoreboard and hand-computed label lists.
module tb_field_layer_classifier;
  import field_layer_classifier_pkg::*;

  typedef struct {
    int lab;
    bit last;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic aresetn;
  logic rdy;
  logic rdy_set;
  bit   tog;
  bit   lat_mode;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   stall_tot;
  int   last_cyc [2];
  exp_t q2 [$];
  exp_t q4 [$];
  int   rx2 [$];
  int   rx4 [$];
  int   thr_v [$];
  int   smp_v [$];
  int   exp_v [$];

  logic busy2, eo2, et2, busy4, eo4, et4;

  field_layer_classifier_if #(.WIDTH(32)) s2 ();
  field_layer_classifier_if #(.WIDTH(8))  m2 ();
  field_layer_classifier_if #(.WIDTH(32)) s4 ();
  field_layer_classifier_if #(.WIDTH(8))  m4 ();

  assign m2.tready = rdy;
  assign m4.tready = 1'b1;

  field_layer_classifier #(
    .FIELD_WIDTH(32), .OUT_WIDTH(8), .LAY_NUM(2), .COUNT_WIDTH(32)
  ) dut2 (
    .aclk(clk), .aresetn(aresetn), .s(s2), .m(m2),
    .busy(busy2), .err_order(eo2), .err_trunc(et2)
  );

  field_layer_classifier #(
    .FIELD_WIDTH(32), .OUT_WIDTH(8), .LAY_NUM(4), .COUNT_WIDTH(32)
  ) dut4 (
    .aclk(clk), .aresetn(aresetn), .s(s4), .m(m4),
    .busy(busy4), .err_order(eo4), .err_trunc(et4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rdy = tog ? !rdy : rdy_set;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(expv));
    end
  endtask

  // Label rule: first threshold the field does not exceed, counted from the top label.
  function automatic int model_label(input int f, input int thr[$]);
    for (int j = 0; j < thr.size(); j++) begin
      if (f <= thr[j]) return thr.size() + 1 - j;
    end
    return 1;
  endfunction

  function automatic bit model_order(input int thr[$]);
    for (int k = 1; k < thr.size(); k++) begin
      if (thr[k] <= thr[k-1]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_port(input int sel, input logic valid, input logic ready,
                            input logic last, input logic [7:0] data,
                            inout bit hv, inout logic [7:0] hd, inout logic hl);
    exp_t e;
    bit   empty;
    if (valid) begin
      if (hv) begin
        checks++;
        if (data !== hd || last !== hl) begin
          errors++;
          $display("FAIL stall_hold dut%0d: got %0d/%0d expected %0d/%0d",
                   sel, data, last, hd, hl);
        end
      end
      if (ready) begin
        empty = (sel == 0) ? (q2.size() == 0) : (q4.size() == 0);
        checks++;
        if (empty) begin
          errors++;
          $display("FAIL unexpected_label dut%0d: got %0d expected none", sel, data);
        end else begin
          if (sel == 0) e = q2.pop_front();
          else e = q4.pop_front();
          if (int'(data) != e.lab || last !== e.last) begin
            errors++;
            $display("FAIL label dut%0d: got %0d last %0d expected %0d last %0d",
                     sel, data, last, e.lab, e.last);
          end
          if (sel == 1 || lat_mode) chk("latency", 64'(cyc), 64'(e.cyc + int'(CLS_LAT)));
        end
        if (sel == 0) rx2.push_back(int'(data));
        else rx4.push_back(int'(data));
        if (last) last_cyc[sel] = cyc;
      end
    end
    hv = valid && !ready;
    hd = data;
    hl = last;
  endtask

  initial begin
    bit         hv2, hv4;
    logic [7:0] hd2, hd4;
    logic       hl2, hl4;
    hv2 = 0; hv4 = 0; hd2 = '0; hd4 = '0; hl2 = 0; hl4 = 0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        hv2 = 0;
        hv4 = 0;
      end else begin
        check_port(0, m2.tvalid, m2.tready, m2.tlast, m2.tdata, hv2, hd2, hl2);
        check_port(1, m4.tvalid, m4.tready, m4.tlast, m4.tdata, hv4, hd4, hl4);
      end
    end
  end

  task automatic send_beat(input int sel, input logic [31:0] d, input logic l,
                           input bit is_smp, input int lab, input bit last,
                           output int waits);
    exp_t e;
    bit   ok;
    waits = 0;
    if (sel == 0) begin s2.tdata = d; s2.tvalid = 1'b1; s2.tlast = l; end
    else begin s4.tdata = d; s4.tvalid = 1'b1; s4.tlast = l; end
    forever begin
      @(negedge clk);
      ok = (sel == 0) ? s2.tready : s4.tready;
      if (ok) begin
        if (is_smp) begin
          e.lab = lab; e.last = last; e.cyc = cyc;
          if (sel == 0) q2.push_back(e);
          else q4.push_back(e);
        end
        @(posedge clk);
        #1;
        break;
      end
      waits++;
      if (waits > 200) begin
        checks++;
        errors++;
        $display("FAIL s_tready_timeout dut%0d: got 0 expected 1", sel);
        break;
      end
      @(posedge clk);
      #1;
    end
    if (sel == 0) begin s2.tvalid = 1'b0; s2.tlast = 1'b0; end
    else begin s4.tvalid = 1'b0; s4.tlast = 1'b0; end
  endtask

  task automatic run_frame(input int sel, input int hdr, input int thr[$], input int smp[$],
                           input int tlast_at, input bit junk_last);
    int w;
    send_beat(sel, hdr, junk_last, 0, 0, 0, w);
    chk("hdr_busy", (sel == 0) ? busy2 : busy4, 1);
    chk("hdr_clears_flags", (sel == 0) ? {eo2, et2} : {eo4, et4}, 0);
    for (int k = 0; k < thr.size(); k++) send_beat(sel, thr[k], junk_last, 0, 0, 0, w);
    if (hdr == 0) chk("zero_count_idle", (sel == 0) ? busy2 : busy4, 0);
    else chk("order_flag", (sel == 0) ? eo2 : eo4, model_order(thr));
    for (int i = 0; i < smp.size(); i++) begin
      send_beat(sel, smp[i], (i == tlast_at), 1, model_label(smp[i], thr),
                (i + 1 == hdr) || (i == tlast_at), w);
      stall_tot += w;
    end
  endtask

  task automatic wait_idle(input int sel, output int c);
    int g;
    g = 0;
    forever begin
      @(negedge clk);
      if (((sel == 0) ? busy2 : busy4) == 1'b0) break;
      g++;
      if (g > 200) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout dut%0d: got busy 1 expected 0", sel);
        break;
      end
    end
    c = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rx(input int sel, input string name, input int expq[$]);
    int got [$];
    if (sel == 0) got = rx2;
    else got = rx4;
    chk({name, "_count"}, 64'(got.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < got.size(); i++) chk(name, got[i], expq[i]);
  endtask

  initial begin
    int ic;
    aresetn = 1'b0;
    rdy_set = 1'b1; tog = 0; lat_mode = 0; stall_tot = 0;
    last_cyc[0] = 0; last_cyc[1] = 0;
    s2.tdata = '0; s2.tvalid = 1'b0; s2.tlast = 1'b0;
    s4.tdata = '0; s4.tvalid = 1'b0; s4.tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {m2.tvalid, m2.tlast, m2.tdata, s2.tready, busy2, eo2, et2}, 0);
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_s_tready", s2.tready, 1);

    // Basic frame, always ready: latency and busy timing.
    lat_mode = 1;
    thr_v = '{-100, 200}; smp_v = '{-150, -100, 0, 500};
    rx2.delete();
    run_frame(0, 4, thr_v, smp_v, -1, 0);
    wait_idle(0, ic);
    chk("busy_fall", 64'(ic), 64'(last_cyc[0] + 1));
    exp_v = '{3, 3, 2, 1};
    chk_rx(0, "basic_labels", exp_v);
    chk("basic_flags", {eo2, et2}, 0);

    // Same frame with m_tready toggling.
    lat_mode = 0; tog = 1; stall_tot = 0;
    rx2.delete();
    run_frame(0, 4, thr_v, smp_v, -1, 0);
    wait_idle(0, ic);
    tog = 0;
    chk_rx(0, "toggle_labels", exp_v);
    chk("toggle_backpressure", 64'(stall_tot > 0), 1);

    // Descending thresholds and early tlast.
    thr_v = '{10, 5}; smp_v = '{3, 7, 20};
    rx2.delete();
    run_frame(0, 5, thr_v, smp_v, 2, 0);
    wait_idle(0, ic);
    exp_v = '{3, 3, 1};
    chk_rx(0, "trunc_labels", exp_v);
    chk("trunc_flags", {eo2, et2}, 2'b11);
    chk("q2_drained", 64'(q2.size()), 0);

    // Zero-count frame: no output.
    thr_v = '{1, 2}; smp_v.delete();
    rx2.delete();
    run_frame(0, 0, thr_v, smp_v, -1, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("zero_count_no_labels", 64'(rx2.size()), 0);

    // Normal frame after the empty one.
    lat_mode = 1;
    thr_v = '{-100, 200}; smp_v = '{-150, -100, 0, 500};
    run_frame(0, 4, thr_v, smp_v, -1, 0);
    wait_idle(0, ic);
    exp_v = '{3, 3, 2, 1};
    chk_rx(0, "after_zero_labels", exp_v);

    // Reset with two labels in flight.
    lat_mode = 0; rdy_set = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    thr_v = '{5, 1}; smp_v = '{0, 9};
    run_frame(0, 4, thr_v, smp_v, -1, 0);
    @(posedge clk);
    #1;
    aresetn = 1'b0;
    #1;
    chk("midframe_reset_outputs",
        {m2.tvalid, m2.tlast, m2.tdata, s2.tready, busy2, eo2, et2}, 0);
    q2.delete();
    rdy_set = 1'b1;
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    rx2.delete();
    repeat (6) @(posedge clk);
    #1;
    chk("no_label_after_reset", 64'(rx2.size()), 0);
    thr_v = '{0, 0}; smp_v = '{0};
    run_frame(0, 1, thr_v, smp_v, -1, 0);
    wait_idle(0, ic);
    exp_v = '{3};
    chk_rx(0, "post_reset_labels", exp_v);
    chk("post_reset_order", eo2, 1);

    // Four-threshold build, tlast on header/thresholds ignored.
    thr_v = '{-3, -1, 1, 3}; smp_v = '{-5, -2, 0, 2, 9};
    rx4.delete();
    run_frame(1, 5, thr_v, smp_v, -1, 1);
    wait_idle(1, ic);
    exp_v = '{5, 4, 3, 2, 1};
    chk_rx(1, "lay4_labels", exp_v);
    chk("lay4_flags", {eo4, et4}, 0);
    chk("q4_drained", 64'(q4.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
